// File: rtl/ux607_sram_icb_arbt_pkg.sv
// ux607_sram_icb_arbt_pkg: shared port IDs and ICB command pack width for the SRAM ICB arbiter
package ux607_sram_icb_arbt_pkg;

    localparam logic ARBT_ID_CORE = 1'b0;
    localparam logic ARBT_ID_SYS  = 1'b1;

    // {read, addr, wdata, wmask, usr} at the default widths
    localparam int ICB_CMD_PACK_W = 32 + 32 + 4 + 3 + 1;

    function automatic int icb_cmd_pack_w(input int aw, input int dw, input int mw, input int usr_w);
        return aw + dw + mw + usr_w + 1;
    endfunction

endpackage

// File: rtl/ux607_sram_arbt_idfifo.sv
// ux607_sram_arbt_idfifo: OSD-deep FIFO of 1-bit port ids with explicit full/empty flags
module ux607_sram_arbt_idfifo #(
    parameter int OSD = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PW = (OSD > 1) ? $clog2(OSD) : 1;

    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic [OSD-1:0] mem;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(OSD - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head = mem[rptr];

    // Pointers wrap modulo OSD; flags disambiguate the equal-pointer case
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            mem   <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push) begin
                mem[wptr] <= push_id;
                wptr      <= inc(wptr);
            end
            if (pop)
                rptr <= inc(rptr);
            if (push && !pop) begin
                full  <= (inc(wptr) == rptr);
                empty <= 1'b0;
            end else if (pop && !push) begin
                empty <= (inc(rptr) == wptr);
                full  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ux607_sram_icb_arbt.sv
// ux607_sram_icb_arbt: two-port ICB arbiter (core/system) in front of one SRAM ICB controller
// Optional anti-starvation for port 1: define UX607_SRAM_ARBT_ANTISTARVE_EN
module ux607_sram_icb_arbt
    import ux607_sram_icb_arbt_pkg::*;
#(
    parameter int DW       = 32,
    parameter int MW       = 4,
    parameter int AW       = 32,
    parameter int USR_W    = 3,
    parameter int OSD      = 2,
    parameter int STARVE_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i0_icb_cmd_valid,
    output logic                i0_icb_cmd_ready,
    input  logic                i0_icb_cmd_read,
    input  logic [AW-1:0]       i0_icb_cmd_addr,
    input  logic [DW-1:0]       i0_icb_cmd_wdata,
    input  logic [MW-1:0]       i0_icb_cmd_wmask,
    input  logic [USR_W-1:0]    i0_icb_cmd_usr,
    output logic                i0_icb_rsp_valid,
    input  logic                i0_icb_rsp_ready,
    output logic [DW-1:0]       i0_icb_rsp_rdata,
    output logic [USR_W-1:0]    i0_icb_rsp_usr,
    input  logic                i1_icb_cmd_valid,
    output logic                i1_icb_cmd_ready,
    input  logic                i1_icb_cmd_read,
    input  logic [AW-1:0]       i1_icb_cmd_addr,
    input  logic [DW-1:0]       i1_icb_cmd_wdata,
    input  logic [MW-1:0]       i1_icb_cmd_wmask,
    input  logic [USR_W-1:0]    i1_icb_cmd_usr,
    output logic                i1_icb_rsp_valid,
    input  logic                i1_icb_rsp_ready,
    output logic [DW-1:0]       i1_icb_rsp_rdata,
    output logic [USR_W-1:0]    i1_icb_rsp_usr,
    output logic                o_icb_cmd_valid,
    input  logic                o_icb_cmd_ready,
    output logic                o_icb_cmd_read,
    output logic [AW-1:0]       o_icb_cmd_addr,
    output logic [DW-1:0]       o_icb_cmd_wdata,
    output logic [MW-1:0]       o_icb_cmd_wmask,
    output logic [USR_W-1:0]    o_icb_cmd_usr,
    input  logic                o_icb_rsp_valid,
    output logic                o_icb_rsp_ready,
    input  logic [DW-1:0]       o_icb_rsp_rdata,
    input  logic [USR_W-1:0]    o_icb_rsp_usr,
    input  logic [STARVE_W-1:0] starve_max,
    output logic                arbt_active
);

    localparam int CW = icb_cmd_pack_w(AW, DW, MW, USR_W);

    logic          grant;
    logic          grant_unl;
    logic          lock;
    logic          lock_id;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_head;
    logic          cmd_hs;
    logic          rsp_hs;
    logic [CW-1:0] i0_pack;
    logic [CW-1:0] i1_pack;

    assign i0_pack = {i0_icb_cmd_read, i0_icb_cmd_addr, i0_icb_cmd_wdata, i0_icb_cmd_wmask, i0_icb_cmd_usr};
    assign i1_pack = {i1_icb_cmd_read, i1_icb_cmd_addr, i1_icb_cmd_wdata, i1_icb_cmd_wmask, i1_icb_cmd_usr};

`ifdef UX607_SRAM_ARBT_ANTISTARVE_EN
    logic [STARVE_W-1:0] starve_cnt;
    logic                sys_prio;

    assign sys_prio = (starve_max != '0) && (starve_cnt >= starve_max);

    // Starved port 1 jumps ahead of port 0 for the next unlocked grant
    always_comb begin
        grant_unl = sys_prio ? (i1_icb_cmd_valid ? ARBT_ID_SYS : ARBT_ID_CORE)
                             : (i0_icb_cmd_valid ? ARBT_ID_CORE : ARBT_ID_SYS);
    end

    // Count cycles port 1 waits ungranted; saturate, clear on its acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (i1_icb_cmd_valid && i1_icb_cmd_ready)
            starve_cnt <= '0;
        else if (i1_icb_cmd_valid && grant != ARBT_ID_SYS && starve_cnt != '1)
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    logic unused_starve_max;

    assign unused_starve_max = ^starve_max;

    // Pure fixed priority: port 0 always wins
    always_comb begin
        grant_unl = i0_icb_cmd_valid ? ARBT_ID_CORE : ARBT_ID_SYS;
    end
`endif

    assign grant  = lock ? lock_id : grant_unl;
    assign cmd_hs = o_icb_cmd_valid && o_icb_cmd_ready;
    assign rsp_hs = o_icb_rsp_valid && o_icb_rsp_ready;

    assign o_icb_cmd_valid  = (grant ? i1_icb_cmd_valid : i0_icb_cmd_valid) && !fifo_full;
    assign {o_icb_cmd_read, o_icb_cmd_addr, o_icb_cmd_wdata, o_icb_cmd_wmask, o_icb_cmd_usr} =
        grant ? i1_pack : i0_pack;
    assign i0_icb_cmd_ready = o_icb_cmd_ready && grant == ARBT_ID_CORE && !fifo_full;
    assign i1_icb_cmd_ready = o_icb_cmd_ready && grant == ARBT_ID_SYS && !fifo_full;

    // Hold the grant while the downstream stalls a presented command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock    <= 1'b0;
            lock_id <= ARBT_ID_CORE;
        end else if (o_icb_cmd_valid && !o_icb_cmd_ready) begin
            lock    <= 1'b1;
            lock_id <= grant;
        end else if (cmd_hs) begin
            lock <= 1'b0;
        end
    end

    ux607_sram_arbt_idfifo #(.OSD(OSD)) u_idfifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (cmd_hs),
        .push_id (grant),
        .pop     (rsp_hs),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    assign i0_icb_rsp_valid = o_icb_rsp_valid && !fifo_empty && fifo_head == ARBT_ID_CORE;
    assign i1_icb_rsp_valid = o_icb_rsp_valid && !fifo_empty && fifo_head == ARBT_ID_SYS;
    assign o_icb_rsp_ready  = (fifo_head ? i1_icb_rsp_ready : i0_icb_rsp_ready) && !fifo_empty;
    assign i0_icb_rsp_rdata = o_icb_rsp_rdata;
    assign i1_icb_rsp_rdata = o_icb_rsp_rdata;
    assign i0_icb_rsp_usr   = o_icb_rsp_usr;
    assign i1_icb_rsp_usr   = o_icb_rsp_usr;

    assign arbt_active = i0_icb_cmd_valid || i1_icb_cmd_valid || !fifo_empty;

endmodule

// File: tb/tb_ux607_sram_icb_arbt.sv
// tb_ux607_sram_icb_arbt: directed scoreboard bench for the two-port SRAM ICB arbiter
module tb_ux607_sram_icb_arbt;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i0_v, i0_cr, i0_rd, i0_rv, i0_rr;
    logic [31:0] i0_a, i0_wd, i0_rdata;
    logic [3:0]  i0_wm;
    logic [2:0]  i0_u, i0_ru;
    logic        i1_v, i1_cr, i1_rd, i1_rv, i1_rr;
    logic [31:0] i1_a, i1_wd, i1_rdata;
    logic [3:0]  i1_wm;
    logic [2:0]  i1_u, i1_ru;
    logic        o_v, o_cr, o_read, o_rv, o_rr;
    logic [31:0] o_a, o_wd, o_rd;
    logic [3:0]  o_wm;
    logic [2:0]  o_u, o_ru;
    logic [3:0]  starve_max;
    logic        active;

    int          vecs = 0;
    int          errs = 0;
    bit          ex_id[$];
    logic [2:0]  ex_usr[$];
    bit          cur_id;
    logic [2:0]  cur_usr;
    logic [31:0] cur_data;
    bit          rsp_on = 1'b0;

    always #5 clk = ~clk;

    ux607_sram_icb_arbt dut (
        .clk(clk), .rst_n(rst_n),
        .i0_icb_cmd_valid(i0_v), .i0_icb_cmd_ready(i0_cr), .i0_icb_cmd_read(i0_rd),
        .i0_icb_cmd_addr(i0_a), .i0_icb_cmd_wdata(i0_wd), .i0_icb_cmd_wmask(i0_wm),
        .i0_icb_cmd_usr(i0_u), .i0_icb_rsp_valid(i0_rv), .i0_icb_rsp_ready(i0_rr),
        .i0_icb_rsp_rdata(i0_rdata), .i0_icb_rsp_usr(i0_ru),
        .i1_icb_cmd_valid(i1_v), .i1_icb_cmd_ready(i1_cr), .i1_icb_cmd_read(i1_rd),
        .i1_icb_cmd_addr(i1_a), .i1_icb_cmd_wdata(i1_wd), .i1_icb_cmd_wmask(i1_wm),
        .i1_icb_cmd_usr(i1_u), .i1_icb_rsp_valid(i1_rv), .i1_icb_rsp_ready(i1_rr),
        .i1_icb_rsp_rdata(i1_rdata), .i1_icb_rsp_usr(i1_ru),
        .o_icb_cmd_valid(o_v), .o_icb_cmd_ready(o_cr), .o_icb_cmd_read(o_read),
        .o_icb_cmd_addr(o_a), .o_icb_cmd_wdata(o_wd), .o_icb_cmd_wmask(o_wm),
        .o_icb_cmd_usr(o_u), .o_icb_rsp_valid(o_rv), .o_icb_rsp_ready(o_rr),
        .o_icb_rsp_rdata(o_rd), .o_icb_rsp_usr(o_ru),
        .starve_max(starve_max), .arbt_active(active)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expect port `id` to own the merged command; record it when accepted
    task automatic cmd_chk(input bit id);
        chk("cmd_valid", o_v, 1'b1);
        chk("cmd_addr", o_a, id ? i1_a : i0_a);
        chk("cmd_read", o_read, id ? i1_rd : i0_rd);
        chk("cmd_wdata", o_wd, id ? i1_wd : i0_wd);
        chk("cmd_wmask", o_wm, id ? i1_wm : i0_wm);
        chk("cmd_usr", o_u, id ? i1_u : i0_u);
        chk("cmd_ready0", i0_cr, o_cr && !id);
        chk("cmd_ready1", i1_cr, o_cr && id);
        if (o_cr) begin
            ex_id.push_back(id);
            ex_usr.push_back(id ? i1_u : i0_u);
        end
    endtask

    // Present the response of the oldest outstanding command
    task automatic rsp_drive(input logic [31:0] d);
        if (ex_id.size() == 0) begin
            vecs++;
            errs++;
            $error("FAIL sb_underflow observed=0 expected=1");
        end else begin
            cur_id   = ex_id.pop_front();
            cur_usr  = ex_usr.pop_front();
            cur_data = d;
            o_rv     = 1'b1;
            o_rd     = d;
            o_ru     = cur_usr;
            rsp_on   = 1'b1;
        end
    endtask

    task automatic tick();
        if (rsp_on) begin
            chk("rsp_valid0", i0_rv, !cur_id);
            chk("rsp_valid1", i1_rv, cur_id);
            chk("rsp_ready", o_rr, 1'b1);
            chk("rsp_rdata", cur_id ? i1_rdata : i0_rdata, cur_data);
            chk("rsp_usr", cur_id ? i1_ru : i0_ru, cur_usr);
        end
        @(posedge clk);
        #1;
        o_rv   = 1'b0;
        rsp_on = 1'b0;
    endtask

    task automatic drain(input int n, input logic [31:0] base);
        i0_v = 1'b0;
        i1_v = 1'b0;
        for (int j = 0; j < n; j++) begin
            rsp_drive(base + 32'(j));
            #1;
            tick();
        end
        chk("drained_idle", active, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        {i0_v, i1_v, o_cr, o_rv} = '0;
        i0_rd = 1'b1;  i0_a = 32'h0; i0_wd = 32'h0A0A_0000; i0_wm = 4'h3; i0_u = 3'd1; i0_rr = 1'b1;
        i1_rd = 1'b0;  i1_a = 32'h0; i1_wd = 32'h1B1B_0000; i1_wm = 4'hC; i1_u = 3'd5; i1_rr = 1'b1;
        o_rd = '0;
        o_ru = '0;
`ifdef UX607_SRAM_ARBT_ANTISTARVE_EN
        starve_max = 4'd0;
`else
        starve_max = 4'd3;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_active", active, 1'b0);
        chk("rst_cmd_valid", o_v, 1'b0);
        chk("rst_rsp_ready", o_rr, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_active", active, 1'b0);

        // Fixed priority: four back-to-back grants to port 0, port 1 waits
        i0_v = 1'b1; i1_v = 1'b1; o_cr = 1'b1; i1_a = 32'h200;
        for (int k = 0; k < 4; k++) begin
            i0_a = 32'h100 + 32'(k);
            if (k > 0) rsp_drive(32'hD0 + 32'(k - 1));
            #1;
            cmd_chk(1'b0);
            tick();
        end
        drain(1, 32'hD3);

        // Stall with port 0 granted; port 1 arrives mid-stall
        o_cr = 1'b0; i0_v = 1'b1; i0_a = 32'h300;
        #1; cmd_chk(1'b0); tick();
        i1_v = 1'b1; i1_a = 32'h400;
        #1; cmd_chk(1'b0); tick();
        #1; cmd_chk(1'b0); tick();
        o_cr = 1'b1;
        #1; cmd_chk(1'b0); tick();
        i0_v = 1'b0;
        #1; cmd_chk(1'b1); tick();
        i1_v = 1'b0;
        #1; chk("two_outstanding", active, 1'b1);
        drain(2, 32'hE0);

        // Stall with port 1 granted; higher-priority port 0 must not steal it
        o_cr = 1'b0; i1_v = 1'b1; i1_a = 32'h500;
        #1; cmd_chk(1'b1); tick();
        i0_v = 1'b1; i0_a = 32'h600;
        #1; cmd_chk(1'b1); tick();
        o_cr = 1'b1;
        #1; cmd_chk(1'b1); tick();
        i1_v = 1'b0;
        #1; cmd_chk(1'b0); tick();
        drain(2, 32'hE8);

        // FIFO full: third command blocked, also in the cycle of a pop
        i0_rr = 1'b0; o_cr = 1'b1; i0_v = 1'b1; i0_a = 32'h900;
        #1; cmd_chk(1'b0); tick();
        i0_a = 32'h904;
        #1; cmd_chk(1'b0); tick();
        i0_a = 32'h908; o_rv = 1'b1; o_rd = 32'hF0; o_ru = ex_usr[0];
        #1;
        chk("full_cmd_valid", o_v, 1'b0);
        chk("full_cmd_ready", i0_cr, 1'b0);
        chk("rsp_held_valid", i0_rv, 1'b1);
        chk("rsp_held_ready", o_rr, 1'b0);
        tick();
        i0_rr = 1'b1;
        rsp_drive(32'hF0);
        #1;
        chk("pop_cycle_cmd_ready", i0_cr, 1'b0);
        chk("pop_cycle_cmd_valid", o_v, 1'b0);
        tick();
        #1; cmd_chk(1'b0); tick();
        drain(2, 32'hF1);

        // Interleaved i0,i1,i0 with responses 0xA,0xB,0xC
        i0_v = 1'b1; i0_a = 32'hA00; i0_u = 3'd2;
        #1; cmd_chk(1'b0); tick();
        i0_v = 1'b0; i1_v = 1'b1; i1_a = 32'hB00; i1_u = 3'd6;
        #1; cmd_chk(1'b1); tick();
        i1_v = 1'b0; i0_v = 1'b1; i0_a = 32'hA04;
        rsp_drive(32'hA);
        #1; chk("interleave_full", o_v, 1'b0); tick();
        rsp_drive(32'hB);
        #1; cmd_chk(1'b0); tick();
        drain(1, 32'hC);

`ifdef UX607_SRAM_ARBT_ANTISTARVE_EN
        // Anti-starvation: port 1 wins on its fourth waiting cycle
        starve_max = 4'd3; i0_v = 1'b1; i1_v = 1'b1; o_cr = 1'b1; i1_a = 32'h800;
        for (int j = 0; j < 5; j++) begin
            i0_a = 32'h700 + 32'(j);
            if (j > 0) rsp_drive(32'h70 + 32'(j));
            #1;
            cmd_chk(j == 3);
            tick();
        end
        drain(1, 32'h7F);
        starve_max = 4'd0;
`endif

        // Reset with two ids outstanding; FIFO must come back empty
        o_cr = 1'b1; i0_v = 1'b1; i0_a = 32'hC00;
        #1; cmd_chk(1'b0); tick();
        i0_a = 32'hC04;
        #1; cmd_chk(1'b0); tick();
        i0_v = 1'b0;
        #1; chk("pre_rst_active", active, 1'b1);
        rst_n = 1'b0; o_rv = 1'b1;
        #1;
        chk("mid_rst_active", active, 1'b0);
        chk("mid_rst_cmd_valid", o_v, 1'b0);
        chk("mid_rst_rsp_valid0", i0_rv, 1'b0);
        chk("mid_rst_rsp_valid1", i1_rv, 1'b0);
        chk("mid_rst_rsp_ready", o_rr, 1'b0);
        ex_id.delete();
        ex_usr.delete();
        o_rv = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        i1_v = 1'b1; i1_a = 32'hD00;
        #1; cmd_chk(1'b1); tick();
        drain(1, 32'h55);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
